// File: rtl/vga_timing.sv
// Raster timing generator: pixel strobe, current/next coordinates, frame count,
// visible qualifier and VGA syncs, all registered and advancing on pixel_en.
module vga_timing #(
  parameter int CLK_DIV     = 1,
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pixel_en,
  output logic [9:0]  position_x,
  output logic [8:0]  position_y,
  output logic [9:0]  position_x_NEXT,
  output logic [8:0]  position_y_NEXT,
  output logic [31:0] frame,
  output logic        visible,
  output logic        line_start,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0]      H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0]      V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0]      HS_BEG   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0]      HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0]      VS_BEG   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0]      VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  generate
    if (CLK_DIV < 1 || H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_param_check
      $error("vga_timing: illegal parameters (CLK_DIV must be >= 1, totals <= 1024)");
    end
  endgenerate

  logic [DIV_W-1:0] div;
  // h_nxt/v_nxt hold the coordinate the next advance will present; the
  // current position is simply the previous value of this pair.
  logic [9:0]       h_nxt, v_nxt;
  logic [9:0]       h_step, v_step;

  function automatic logic sync_level(input logic [10:0] c, input logic [10:0] beg,
                                      input logic [10:0] fin);
    return (c >= beg && c < fin) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  endfunction

  always_comb begin
    h_step = h_nxt + 10'd1;
    v_step = v_nxt;
    if (h_nxt == H_LAST) begin
      h_step = '0;
      v_step = (v_nxt == V_LAST) ? '0 : v_nxt + 10'd1;
    end
  end

  assign position_x_NEXT = h_nxt;
  assign position_y_NEXT = v_nxt[8:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      div         <= '0;
      pixel_en    <= 1'b0;
      position_x  <= '0;
      position_y  <= '0;
      h_nxt       <= 10'd1;
      v_nxt       <= '0;
      frame       <= '0;
      visible     <= 1'b1;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
    end else begin
      div      <= (div == DIV_LAST) ? '0 : div + DIV_ONE;
      pixel_en <= (div == DIV_LAST);
      if (pixel_en) begin
        position_x  <= h_nxt;
        position_y  <= v_nxt[8:0];
        h_nxt       <= h_step;
        v_nxt       <= v_step;
        // Landing on (0,0) means a full frame has just been completed.
        if (h_nxt == 10'd0 && v_nxt == 10'd0) frame <= frame + 32'd1;
        visible     <= ({1'b0, h_nxt} < H_VIS) && ({1'b0, v_nxt} < V_VIS);
        line_start  <= (h_nxt == 10'd0);
        frame_start <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
        hsync       <= sync_level({1'b0, h_nxt}, HS_BEG, HS_END);
        vsync       <= sync_level({1'b0, v_nxt}, VS_BEG, VS_END);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: three instances (full VGA line, short-line
// CLK_DIV=1, short-line CLK_DIV=4) checked every cycle against a raster model.
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        pen [3];
  logic [9:0]  px  [3];
  logic [8:0]  py  [3];
  logic [9:0]  nx  [3];
  logic [8:0]  ny  [3];
  logic [31:0] fr  [3];
  logic        vis [3];
  logic        ls  [3];
  logic        fs  [3];
  logic        hs  [3];
  logic        vs  [3];

  vga_timing u_full (
    .clk(clk), .rst(rst), .pixel_en(pen[0]), .position_x(px[0]), .position_y(py[0]),
    .position_x_NEXT(nx[0]), .position_y_NEXT(ny[0]), .frame(fr[0]), .visible(vis[0]),
    .line_start(ls[0]), .frame_start(fs[0]), .hsync(hs[0]), .vsync(vs[0]));

  vga_timing #(.H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1)) u_small (
    .clk(clk), .rst(rst), .pixel_en(pen[1]), .position_x(px[1]), .position_y(py[1]),
    .position_x_NEXT(nx[1]), .position_y_NEXT(ny[1]), .frame(fr[1]), .visible(vis[1]),
    .line_start(ls[1]), .frame_start(fs[1]), .hsync(hs[1]), .vsync(vs[1]));

  vga_timing #(.CLK_DIV(4), .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1)) u_div (
    .clk(clk), .rst(rst), .pixel_en(pen[2]), .position_x(px[2]), .position_y(py[2]),
    .position_x_NEXT(nx[2]), .position_y_NEXT(ny[2]), .frame(fr[2]), .visible(vis[2]),
    .line_start(ls[2]), .frame_start(fs[2]), .hsync(hs[2]), .vsync(vs[2]));

  localparam int    DIV_I [3] = '{1, 1, 4};
  localparam int    HV_I  [3] = '{640, 4, 4};
  localparam int    HF_I  [3] = '{16, 1, 1};
  localparam int    HS_I  [3] = '{96, 2, 2};
  localparam int    HB_I  [3] = '{48, 1, 1};
  localparam int    VV = 480, VF = 10, VS = 2, VB = 33;
  localparam string INAME [3] = '{"full", "small", "div4"};

  typedef enum int {S_PEN, S_PX, S_PY, S_NX, S_NY, S_FR, S_VIS, S_LS, S_FS, S_HS, S_VS} sig_e;
  typedef struct {
    string       tag;
    int          inst;
    sig_e        sig;
    logic [31:0] exp;
  } item_t;

  item_t sb[$];
  int    n_cmp, n_fail;
  int    k;                       // clk edges since reset release
  bit    first_pass;
  int    hs_low, vs_low, vis_cnt;

  function automatic logic [31:0] obs(input int i, input sig_e s);
    case (s)
      S_PEN:   return 32'(pen[i]);
      S_PX:    return 32'(px[i]);
      S_PY:    return 32'(py[i]);
      S_NX:    return 32'(nx[i]);
      S_NY:    return 32'(ny[i]);
      S_FR:    return fr[i];
      S_VIS:   return 32'(vis[i]);
      S_LS:    return 32'(ls[i]);
      S_FS:    return 32'(fs[i]);
      S_HS:    return 32'(hs[i]);
      default: return 32'(vs[i]);
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  task automatic push(input string tag, input int i, input sig_e s, input logic [31:0] e);
    item_t it;
    it.tag  = {INAME[i], ".", tag};
    it.inst = i;
    it.sig  = s;
    it.exp  = e;
    sb.push_back(it);
  endtask

  // Expected outputs of instance i after kk edges since release (kk=0: reset values).
  task automatic push_model(input int i, input int kk);
    int d, ht, vt, a, h, v, f, hn, vn;
    d  = DIV_I[i];
    ht = HV_I[i] + HF_I[i] + HS_I[i] + HB_I[i];
    vt = VV + VF + VS + VB;
    a  = (kk == 0) ? 0 : (kk - 1) / d;
    h  = a % ht;
    v  = (a / ht) % vt;
    f  = a / (ht * vt);
    hn = (a + 1) % ht;
    vn = ((a + 1) / ht) % vt;
    push("pen",   i, S_PEN, 32'(kk >= 1 && (kk % d) == 0));
    push("px",    i, S_PX,  32'(h));
    push("py",    i, S_PY,  32'(v % 512));
    push("nx",    i, S_NX,  32'(hn));
    push("ny",    i, S_NY,  32'(vn % 512));
    push("frame", i, S_FR,  32'(f));
    push("vis",   i, S_VIS, 32'(h < HV_I[i] && v < VV));
    push("ls",    i, S_LS,  32'(h == 0));
    push("fs",    i, S_FS,  32'(h == 0 && v == 0));
    push("hsync", i, S_HS,  32'(!(h >= HV_I[i] + HF_I[i] && h < HV_I[i] + HF_I[i] + HS_I[i])));
    push("vsync", i, S_VS,  32'(!(v >= VV + VF && v < VV + VF + VS)));
  endtask

  task automatic drain();
    item_t it;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      check_val(it.tag, obs(it.inst, it.sig), it.exp);
    end
  endtask

  task automatic tick();
    int kn;
    kn = rst ? 0 : k + 1;
    for (int i = 0; i < 3; i++) push_model(i, kn);
    @(posedge clk);
    #1;
    k = kn;
    drain();
    if (first_pass) begin
      if (k >= 1 && k <= 800 && hs[0] == 1'b0) hs_low++;
      if (k >= 1 && k <= 4200) begin
        if (vs[1] == 1'b0) vs_low++;
        if (vis[1]) vis_cnt++;
      end
    end
  endtask

  task automatic run_to(input int target);
    while (k < target) tick();
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; k = 0;
    hs_low = 0; vs_low = 0; vis_cnt = 0;
    first_pass = 1'b1;
    rst = 1'b1;
    repeat (3) tick();

    rst = 1'b0;
    for (int i = 0; i < 3; i++) push_model(i, 0);
    drain();

    push("pen_first", 0, S_PEN, 1);
    push("px_first",  0, S_PX,  0);
    tick();
    push("px_adv1", 0, S_PX, 1);
    push("nx_adv1", 0, S_NX, 2);
    tick();

    run_to(3);
    push("pen_4th", 2, S_PEN, 1);
    push("px_hold", 2, S_PX,  0);
    tick();
    push("pen_off", 2, S_PEN, 0);
    push("px_adv",  2, S_PX,  1);
    tick();

    run_to(799);
    push("eol_px", 0, S_PX, 799);
    push("eol_nx", 0, S_NX, 0);
    push("eol_ny", 0, S_NY, 1);
    tick();
    push("wrap_px",  0, S_PX,  0);
    push("wrap_py",  0, S_PY,  1);
    push("wrap_ls",  0, S_LS,  1);
    push("wrap_fs",  0, S_FS,  0);
    push("wrap_vis", 0, S_VIS, 1);
    tick();
    check_val("full.hsync_low_pixels", hs_low, 96);

    run_to(4098);
    push("v512_py",  1, S_PY,  0);
    push("v512_vis", 1, S_VIS, 0);
    tick();

    run_to(4199);
    push("last_px", 1, S_PX, 7);
    push("last_py", 1, S_PY, 12);
    push("last_nx", 1, S_NX, 0);
    push("last_ny", 1, S_NY, 0);
    tick();
    push("fwrap_frame", 1, S_FR, 1);
    push("fwrap_px",    1, S_PX, 0);
    push("fwrap_py",    1, S_PY, 0);
    push("fwrap_fs",    1, S_FS, 1);
    tick();
    check_val("small.vsync_low_pixels", vs_low, 16);
    check_val("small.visible_pixels", vis_cnt, 1920);

    run_to(16799);
    push("frame_before", 2, S_FR, 0);
    tick();
    push("frame_after", 2, S_FR, 1);
    push("frame_px",    2, S_PX, 0);
    push("frame_py",    2, S_PY, 0);
    tick();

    run_to(22604);
    first_pass = 1'b0;
    push("mid_px",    1, S_PX, 3);
    push("mid_py",    1, S_PY, 200);
    push("mid_frame", 1, S_FR, 5);
    drain();
    rst = 1'b1;
    push("mrst_px",    1, S_PX,  0);
    push("mrst_py",    1, S_PY,  0);
    push("mrst_frame", 1, S_FR,  0);
    push("mrst_nx",    1, S_NX,  1);
    push("mrst_ny",    1, S_NY,  0);
    push("mrst_pen",   1, S_PEN, 0);
    tick();
    rst = 1'b0;
    tick();
    push("resume_px", 1, S_PX, 1);
    tick();
    run_to(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
